// File: rtl/mmio_hex_uart_tx_if.sv
// MMIO-word-in / UART-line-out bundle for the hex debug transmitter.
// The master drives the watched word; the slave (transmitter) drives the serial line and status.
interface mmio_hex_uart_tx_if #(
  parameter int DROP_CNT_W = 8
);
  logic [15:0]           data_in;
  logic                  tx;
  logic                  busy;
  logic [DROP_CNT_W-1:0] dropped;

  modport master (
    output data_in,
    input  tx,
    input  busy,
    input  dropped
  );

  modport slave (
    input  data_in,
    output tx,
    output busy,
    output dropped
  );
endinterface

// File: rtl/mmio_hex_uart_tx.sv
// Sends each new value of the MMIO word as 4 uppercase hex chars over UART 8N1, MSB nibble first.
// Define MMIO_UART_CRLF_EN to append CR LF to every message; only one value is ever queued, the rest are counted in dropped.
module mmio_hex_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DROP_CNT_W   = 8
) (
  input  logic                clk,
  input  logic                rst,
  mmio_hex_uart_tx_if.slave   bus
);

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] BIT_END = CNT_W'(CLKS_PER_BIT - 1);

`ifdef MMIO_UART_CRLF_EN
  localparam logic [2:0] LAST_CHAR = 3'd5;
`else
  localparam logic [2:0] LAST_CHAR = 3'd3;
`endif

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [15:0]           last_seen_q, last_seen_d;
  logic [15:0]           pend_val_q,  pend_val_d;
  logic                  pending_q,   pending_d;
  logic [DROP_CNT_W-1:0] dropped_q,   dropped_d;
  logic [1:0]            state_q,     state_d;
  logic [15:0]           msg_q,       msg_d;
  logic [2:0]            char_idx_q,  char_idx_d;
  logic [2:0]            bit_idx_q,   bit_idx_d;
  logic [CNT_W-1:0]      clk_cnt_q,   clk_cnt_d;
  logic                  tx_q,        tx_d;
  logic                  busy_q,      busy_d;

  logic       change;
  logic       consume;
  logic       bit_end;
  logic [2:0] nxt_bit;
  logic [7:0] cur_char;

  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    if (nib < 4'd10) begin
      return 8'h30 + {4'h0, nib};
    end
    return 8'h37 + {4'h0, nib};
  endfunction

  assign change  = (bus.data_in != last_seen_q);
  assign consume = (state_q == S_IDLE) && pending_q;
  assign bit_end = (clk_cnt_q == BIT_END);
  assign nxt_bit = bit_idx_q + 3'd1;

  always_comb begin
    cur_char = 8'h00;
    case (char_idx_q)
      3'd0:    cur_char = hex_ascii(msg_q[15:12]);
      3'd1:    cur_char = hex_ascii(msg_q[11:8]);
      3'd2:    cur_char = hex_ascii(msg_q[7:4]);
      3'd3:    cur_char = hex_ascii(msg_q[3:0]);
`ifdef MMIO_UART_CRLF_EN
      3'd4:    cur_char = 8'h0D;
      3'd5:    cur_char = 8'h0A;
`endif
      default: cur_char = 8'h00;
    endcase
  end

  // A change landing in the consume cycle replaces the slot that was just emptied, so it is not a drop.
  always_comb begin
    last_seen_d = last_seen_q;
    pend_val_d  = pend_val_q;
    pending_d   = pending_q;
    dropped_d   = dropped_q;
    if (change) begin
      last_seen_d = bus.data_in;
      pend_val_d  = bus.data_in;
      pending_d   = 1'b1;
      if (pending_q && !consume && !(&dropped_q)) begin
        dropped_d = dropped_q + 1'b1;
      end
    end else if (consume) begin
      pending_d = 1'b0;
    end
  end

  always_comb begin
    state_d    = state_q;
    msg_d      = msg_q;
    char_idx_d = char_idx_q;
    bit_idx_d  = bit_idx_q;
    clk_cnt_d  = clk_cnt_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    case (state_q)
      S_IDLE: begin
        tx_d       = 1'b1;
        busy_d     = 1'b0;
        clk_cnt_d  = '0;
        char_idx_d = 3'd0;
        bit_idx_d  = 3'd0;
        if (pending_q) begin
          msg_d   = pend_val_q;
          state_d = S_START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      S_START: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          bit_idx_d = 3'd0;
          state_d   = S_DATA;
          tx_d      = cur_char[0];
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            bit_idx_d = 3'd0;
            state_d   = S_STOP;
            tx_d      = 1'b1;
          end else begin
            bit_idx_d = nxt_bit;
            tx_d      = cur_char[nxt_bit];
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          if (char_idx_q == LAST_CHAR) begin
            char_idx_d = 3'd0;
            state_d    = S_IDLE;
            tx_d       = 1'b1;
            busy_d     = 1'b0;
          end else begin
            // Next character starts immediately: no idle gap inside a message.
            char_idx_d = char_idx_q + 3'd1;
            state_d    = S_START;
            tx_d       = 1'b0;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_seen_q <= 16'h0000;
      pend_val_q  <= 16'h0000;
      pending_q   <= 1'b0;
      dropped_q   <= '0;
      state_q     <= S_IDLE;
      msg_q       <= 16'h0000;
      char_idx_q  <= 3'd0;
      bit_idx_q   <= 3'd0;
      clk_cnt_q   <= '0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      last_seen_q <= last_seen_d;
      pend_val_q  <= pend_val_d;
      pending_q   <= pending_d;
      dropped_q   <= dropped_d;
      state_q     <= state_d;
      msg_q       <= msg_d;
      char_idx_q  <= char_idx_d;
      bit_idx_q   <= bit_idx_d;
      clk_cnt_q   <= clk_cnt_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.tx      = tx_q;
  assign bus.busy    = busy_q;
  assign bus.dropped = dropped_q;

endmodule
